// File: rtl/tpu_job_seq.sv
// tpu_job_seq -- job sequencer that acts as the sole MMIO master of the TPU.
// For each accepted descriptor it copies matrices A and B from byte memory
// into the TPU operand buffers, starts the array, polls STATUS until done
// (or until the poll budget runs out), streams the N*N result sums out over
// a valid/ready port and finally clears the TPU done bit.
module tpu_job_seq #(
  parameter int          N          = 4,
  parameter int          DATA_W     = 8,
  parameter int          SUM_W      = 32,
  parameter logic [15:0] TPU_BASE   = 16'h0000,
  parameter int          POLL_LIMIT = 1024
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [15:0]                 job_a_base,
  input  logic [15:0]                 job_b_base,
  input  logic [7:0]                  job_id,

  output logic                        mem_rd_en,
  output logic [15:0]                 mem_rd_addr,
  input  logic [DATA_W-1:0]           mem_rd_data,

  output logic                        mmio_wr,
  output logic                        mmio_rd,
  output logic [15:0]                 mmio_addr,
  output logic [31:0]                 mmio_wdata,
  output logic [3:0]                  mmio_wstrb,
  input  logic [31:0]                 mmio_rdata,
  input  logic                        mmio_ready,

  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [SUM_W-1:0]            res_data,
  output logic [$clog2(N*N)-1:0]      res_idx,
  output logic                        res_last,

  output logic                        job_done,
  output logic                        job_err,
  output logic [7:0]                  done_id,
  output logic                        ctrl_busy
);

  localparam int NUM_EL = N * N;
  localparam int IDX_W  = $clog2(NUM_EL);
  localparam int PCNT_W = $clog2(POLL_LIMIT + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_EL - 1);
  localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_LIMIT - 1);

  localparam logic [15:0] CTRL_ADDR   = TPU_BASE + 16'h0008;
  localparam logic [15:0] STATUS_ADDR = TPU_BASE + 16'h000C;
  localparam logic [15:0] A_ADDR      = TPU_BASE + 16'h0100;
  localparam logic [15:0] B_ADDR      = TPU_BASE + 16'h0200;
  localparam logic [15:0] C_ADDR      = TPU_BASE + 16'h0300;

  localparam logic [31:0] CTRL_START = 32'h0000_0001;
  localparam logic [31:0] CTRL_CLEAR = 32'h0000_0002;

  typedef enum logic [2:0] {
    IDLE,
    LD_A,
    LD_B,
    START,
    POLL,
    RD_C,
    CLEAR
  } state_t;

  // phase_q selects the half of a two-phase element transfer:
  //   LD_A/LD_B: 0 = memory read, 1 = MMIO write of the fetched byte
  //   RD_C:      0 = MMIO read of C[idx], 1 = result presented on res_*
  state_t              state_q, state_d;
  logic                phase_q, phase_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [15:0]         a_base_q, a_base_d;
  logic [15:0]         b_base_q, b_base_d;
  logic [7:0]          id_q, id_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                rd_pend_q, rd_pend_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [PCNT_W-1:0]   poll_cnt_q, poll_cnt_d;
  logic                err_q, err_d;
  logic                job_done_q, job_done_d;
  logic                job_err_q, job_err_d;
  logic [7:0]          done_id_q, done_id_d;

  logic [15:0]         idx_ext;
  logic [DATA_W-1:0]   ld_elem;
  logic                unused_rdata;

  assign idx_ext = 16'(idx_q);

  // Memory data is only valid the cycle after the read strobe, so that cycle
  // uses it directly and later (stalled) cycles use the captured copy.
  assign ld_elem = rd_pend_q ? mem_rd_data : data_q;

  // Upper read-data bits are not needed when SUM_W < 32.
  assign unused_rdata = ^mmio_rdata;

  // State and datapath registers with synchronous reset; reset mid-job simply drops the job.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      phase_q    <= 1'b0;
      idx_q      <= '0;
      a_base_q   <= '0;
      b_base_q   <= '0;
      id_q       <= '0;
      data_q     <= '0;
      rd_pend_q  <= 1'b0;
      sum_q      <= '0;
      poll_cnt_q <= '0;
      err_q      <= 1'b0;
      job_done_q <= 1'b0;
      job_err_q  <= 1'b0;
      done_id_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      idx_q      <= idx_d;
      a_base_q   <= a_base_d;
      b_base_q   <= b_base_d;
      id_q       <= id_d;
      data_q     <= data_d;
      rd_pend_q  <= rd_pend_d;
      sum_q      <= sum_d;
      poll_cnt_q <= poll_cnt_d;
      err_q      <= err_d;
      job_done_q <= job_done_d;
      job_err_q  <= job_err_d;
      done_id_q  <= done_id_d;
    end
  end

  // Next-state logic: every step waits on its handshake, so a stall leaves state and index untouched.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    idx_d      = idx_q;
    a_base_d   = a_base_q;
    b_base_d   = b_base_q;
    id_d       = id_q;
    data_d     = data_q;
    rd_pend_d  = 1'b0;
    sum_d      = sum_q;
    poll_cnt_d = poll_cnt_q;
    err_d      = err_q;
    job_done_d = 1'b0;
    job_err_d  = 1'b0;
    done_id_d  = '0;

    case (state_q)
      IDLE: begin
        if (job_valid) begin
          a_base_d = job_a_base;
          b_base_d = job_b_base;
          id_d     = job_id;
          idx_d    = '0;
          phase_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = LD_A;
        end
      end

      LD_A, LD_B: begin
        if (!phase_q) begin
          rd_pend_d = 1'b1;
          phase_d   = 1'b1;
        end else begin
          data_d = ld_elem;
          if (mmio_ready) begin
            phase_d = 1'b0;
            if (idx_q == LAST_IDX) begin
              idx_d   = '0;
              state_d = (state_q == LD_A) ? LD_B : START;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
      end

      START: begin
        if (mmio_ready) begin
          poll_cnt_d = '0;
          state_d    = POLL;
        end
      end

      POLL: begin
        if (mmio_ready) begin
          poll_cnt_d = poll_cnt_q + 1'b1;
          if (mmio_rdata[1]) begin
            idx_d   = '0;
            phase_d = 1'b0;
            state_d = RD_C;
          end else if (poll_cnt_q == POLL_LAST) begin
            err_d   = 1'b1;
            state_d = CLEAR;
          end
        end
      end

      RD_C: begin
        if (!phase_q) begin
          if (mmio_ready) begin
            sum_d   = mmio_rdata[SUM_W-1:0];
            phase_d = 1'b1;
          end
        end else if (res_ready) begin
          phase_d = 1'b0;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = CLEAR;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      CLEAR: begin
        if (mmio_ready) begin
          job_done_d = 1'b1;
          job_err_d  = err_q;
          done_id_d  = id_q;
          err_d      = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode: strobes, address and data are driven only in the phase that owns the bus.
  always_comb begin
    job_ready   = (state_q == IDLE);
    ctrl_busy   = (state_q != IDLE);
    mem_rd_en   = 1'b0;
    mem_rd_addr = '0;
    mmio_wr     = 1'b0;
    mmio_rd     = 1'b0;
    mmio_addr   = '0;
    mmio_wdata  = '0;
    mmio_wstrb  = '0;
    res_valid   = 1'b0;
    res_data    = '0;
    res_idx     = '0;
    res_last    = 1'b0;

    case (state_q)
      LD_A, LD_B: begin
        if (!phase_q) begin
          mem_rd_en   = 1'b1;
          mem_rd_addr = ((state_q == LD_A) ? a_base_q : b_base_q) + idx_ext;
        end else begin
          mmio_wr                = 1'b1;
          mmio_addr              = ((state_q == LD_A) ? A_ADDR : B_ADDR) + idx_ext;
          mmio_wdata[DATA_W-1:0] = ld_elem;
          mmio_wstrb             = 4'hF;
        end
      end

      START: begin
        mmio_wr    = 1'b1;
        mmio_addr  = CTRL_ADDR;
        mmio_wdata = CTRL_START;
        mmio_wstrb = 4'hF;
      end

      POLL: begin
        mmio_rd   = 1'b1;
        mmio_addr = STATUS_ADDR;
      end

      RD_C: begin
        if (!phase_q) begin
          mmio_rd   = 1'b1;
          mmio_addr = C_ADDR + 16'({idx_q, 2'b00});
        end else begin
          res_valid = 1'b1;
          res_data  = sum_q;
          res_idx   = idx_q;
          res_last  = (idx_q == LAST_IDX);
        end
      end

      CLEAR: begin
        mmio_wr    = 1'b1;
        mmio_addr  = CTRL_ADDR;
        mmio_wdata = CTRL_CLEAR;
        mmio_wstrb = 4'hF;
      end

      default: begin
      end
    endcase
  end

  assign job_done = job_done_q;
  assign job_err  = job_err_q;
  assign done_id  = done_id_q;

endmodule

// File: tb/tb_tpu_job_seq.sv
// tb_tpu_job_seq -- scoreboard bench for tpu_job_seq with a byte memory and a
// small TPU register model. Each job pushes its expected memory reads, MMIO
// transactions, result beats and completion into queues; monitors pop them.
`timescale 1ns/1ps
module tb_tpu_job_seq;

  localparam int N      = 4;
  localparam int NE     = N * N;
  localparam int PL     = 20;
  localparam int BUDGET = 3000;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_a_base;
  logic [15:0] job_b_base;
  logic [7:0]  job_id;
  logic        mem_rd_en;
  logic [15:0] mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic        mmio_wr;
  logic        mmio_rd;
  logic [15:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [3:0]  mmio_wstrb;
  logic [31:0] mmio_rdata;
  logic        mmio_ready;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_idx;
  logic        res_last;
  logic        job_done;
  logic        job_err;
  logic [7:0]  done_id;
  logic        ctrl_busy;

  always #5 clk = ~clk;

  tpu_job_seq #(
    .N(N), .DATA_W(8), .SUM_W(32), .TPU_BASE(16'h0000), .POLL_LIMIT(PL)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a_base(job_a_base), .job_b_base(job_b_base), .job_id(job_id),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_wstrb(mmio_wstrb),
    .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_idx(res_idx), .res_last(res_last),
    .job_done(job_done), .job_err(job_err), .done_id(done_id), .ctrl_busy(ctrl_busy)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int accept_cyc = 0;
  bit stall_en = 1'b0;
  int cyc3     = 0;
  int done_on_read = 18;

  logic [7:0]  mem [0:65535];
  logic [31:0] a_reg [NE];
  logic [31:0] b_reg [NE];
  logic [31:0] c_reg [NE];
  logic [31:0] msum;
  int          status_cnt;
  logic        tpu_done;
  logic [31:0] exp_c [NE];

  logic [15:0] mem_q  [$];
  logic [48:0] mmio_q [$];
  logic [36:0] res_q  [$];
  logic [8:0]  done_q [$];

  logic [15:0] m_mem;
  logic [48:0] m_mmio;
  logic [36:0] m_res;
  logic [8:0]  m_done;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got event expected none", name);
  endtask

  // Cycle counter used for the end-to-end latency check.
  always @(posedge clk) cyc <= cyc + 1;

  // Byte memory: data appears the cycle after the strobe, filler otherwise.
  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 8'hA5;

  // TPU register model: operand buffers, matmul on start, STATUS read counter.
  always @(posedge clk) begin
    if (rst) begin
      status_cnt <= 0;
    end else begin
      if (mmio_wr && mmio_ready) begin
        if (mmio_addr[15:8] == 8'h01) a_reg[mmio_addr[3:0]] <= mmio_wdata;
        else if (mmio_addr[15:8] == 8'h02) b_reg[mmio_addr[3:0]] <= mmio_wdata;
        else if (mmio_addr == 16'h0008 && mmio_wdata[0]) begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              msum = 32'd0;
              for (int k = 0; k < N; k++) msum = msum + a_reg[r*N+k] * b_reg[k*N+c];
              c_reg[r*N+c] <= msum;
            end
          end
          status_cnt <= 0;
        end
      end
      if (mmio_rd && mmio_ready && mmio_addr == 16'h000C) status_cnt <= status_cnt + 1;
    end
  end

  assign tpu_done = (done_on_read != 0) && (status_cnt + 1 >= done_on_read);

  // Read data is only meaningful on an accepted read; otherwise all ones.
  always_comb begin
    mmio_rdata = 32'hFFFF_FFFF;
    if (mmio_ready && mmio_rd) begin
      if (mmio_addr == 16'h000C) mmio_rdata = {30'd0, tpu_done, !tpu_done};
      else if (mmio_addr >= 16'h0300 && mmio_addr < 16'h0340) mmio_rdata = c_reg[mmio_addr[5:2]];
    end
  end

  // Ready drivers, updated just after each rising edge.
  initial begin
    mmio_ready = 1'b1;
    res_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc3 = (cyc3 + 1) % 3;
      mmio_ready = stall_en ? (cyc3 != 0) : 1'b1;
      res_ready  = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents a transaction.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_rd_en) begin
        if (mem_q.size() == 0) reportFail("mem_rd_unexpected");
        else begin
          m_mem = mem_q.pop_front();
          checkOutput("mem_rd_addr", 64'(mem_rd_addr), 64'(m_mem));
        end
      end
      if (mmio_wr && mmio_rd) reportFail("mmio_both_strobes");
      if ((mmio_wr || mmio_rd) && mmio_ready) begin
        if (mmio_q.size() == 0) reportFail("mmio_unexpected");
        else begin
          m_mmio = mmio_q.pop_front();
          checkOutput("mmio_txn", 64'({mmio_wr, mmio_addr, mmio_wdata}), 64'(m_mmio));
          checkOutput("mmio_wstrb", 64'(mmio_wstrb), mmio_wr ? 64'hF : 64'h0);
        end
      end
      if (res_valid && res_ready) begin
        if (res_q.size() == 0) reportFail("res_unexpected");
        else begin
          m_res = res_q.pop_front();
          checkOutput("res_beat", 64'({res_idx, res_last, res_data}), 64'(m_res));
        end
      end
      if (job_done) begin
        if (done_q.size() == 0) reportFail("job_done_unexpected");
        else begin
          m_done = done_q.pop_front();
          checkOutput("completion", 64'({job_err, done_id}), 64'(m_done));
        end
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_job_ready"},   64'(job_ready),   64'd1);
    checkOutput({tag, "_ctrl_busy"},   64'(ctrl_busy),   64'd0);
    checkOutput({tag, "_mem_rd_en"},   64'(mem_rd_en),   64'd0);
    checkOutput({tag, "_mem_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    checkOutput({tag, "_mmio_wr"},     64'(mmio_wr),     64'd0);
    checkOutput({tag, "_mmio_rd"},     64'(mmio_rd),     64'd0);
    checkOutput({tag, "_mmio_addr"},   64'(mmio_addr),   64'd0);
    checkOutput({tag, "_mmio_wdata"},  64'(mmio_wdata),  64'd0);
    checkOutput({tag, "_mmio_wstrb"},  64'(mmio_wstrb),  64'd0);
    checkOutput({tag, "_res_valid"},   64'(res_valid),   64'd0);
    checkOutput({tag, "_res_data"},    64'(res_data),    64'd0);
    checkOutput({tag, "_res_idx"},     64'(res_idx),     64'd0);
    checkOutput({tag, "_res_last"},    64'(res_last),    64'd0);
    checkOutput({tag, "_job_done"},    64'(job_done),    64'd0);
    checkOutput({tag, "_job_err"},     64'(job_err),     64'd0);
    checkOutput({tag, "_done_id"},     64'(done_id),     64'd0);
  endtask

  // Push the full expected transaction stream for one job, then offer the descriptor.
  task automatic applyStimulus(input logic [7:0] id, input logic [15:0] a_base, input logic [15:0] b_base,
                               input int reads, input bit timeout, input bit expect_on_done);
    logic [15:0] addr;
    int waited;
    for (int i = 0; i < NE; i++) mem_q.push_back(a_base + 16'(i));
    for (int i = 0; i < NE; i++) mem_q.push_back(b_base + 16'(i));
    for (int i = 0; i < NE; i++) begin
      addr = a_base + 16'(i);
      mmio_q.push_back({1'b1, 16'h0100 + 16'(i), 24'd0, mem[addr]});
    end
    for (int i = 0; i < NE; i++) begin
      addr = b_base + 16'(i);
      mmio_q.push_back({1'b1, 16'h0200 + 16'(i), 24'd0, mem[addr]});
    end
    mmio_q.push_back({1'b1, 16'h0008, 32'h1});
    for (int i = 0; i < reads; i++) mmio_q.push_back({1'b0, 16'h000C, 32'h0});
    if (!timeout) begin
      for (int i = 0; i < NE; i++) begin
        mmio_q.push_back({1'b0, 16'h0300 + 16'(4 * i), 32'h0});
        res_q.push_back({4'(i), (i == NE - 1), exp_c[i]});
      end
    end
    mmio_q.push_back({1'b1, 16'h0008, 32'h2});
    done_q.push_back({timeout, id});

    job_id     = id;
    job_a_base = a_base;
    job_b_base = b_base;
    job_valid  = 1'b1;
    waited     = 0;
    while (!job_ready && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (!job_ready) begin
      reportFail("job_accept_timeout");
      job_valid = 1'b0;
    end else begin
      if (expect_on_done) checkOutput("accept_on_done", 64'(job_done), 64'd1);
      accept_cyc = cyc;
      @(posedge clk);
      @(negedge clk);
      job_valid = 1'b0;
    end
  endtask

  task automatic waitDone(output int latency);
    int waited;
    waited = 0;
    while (!job_done && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (!job_done) begin
      reportFail("job_done_timeout");
      latency = -1;
    end else begin
      latency = cyc - accept_cyc;
    end
  endtask

  task automatic waitDrain();
    int waited;
    waited = 0;
    while ((mem_q.size() + mmio_q.size() + res_q.size() + done_q.size()) != 0 && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if ((mem_q.size() + mmio_q.size() + res_q.size() + done_q.size()) != 0) reportFail("drain_timeout");
    repeat (3) @(negedge clk);
  endtask

  // Directed job sequence.
  initial begin
    int lat;
    int waited;
    rst        = 1'b1;
    job_valid  = 1'b0;
    job_id     = 8'h00;
    job_a_base = 16'h0000;
    job_b_base = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < N; i++) mem[i * N + i] = 8'd1;
    for (int i = 0; i < NE; i++) mem[16'h0100 + i] = 8'(i + 1);
    for (int i = 0; i < N; i++) mem[16'h0040 + i * N + i] = 8'd2;
    for (int i = 0; i < NE; i++) mem[16'h0200 + i] = 8'(16 - i);
    mem[16'hFFFA] = 8'd1;
    mem[16'hFFFF] = 8'd1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("por");
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] identity job");
    for (int i = 0; i < NE; i++) exp_c[i] = 32'(i + 1);
    done_on_read = 18;
    applyStimulus(8'h01, 16'h0000, 16'h0100, 18, 1'b0, 1'b0);
    waitDone(lat);
    checkOutput("identity_latency", 64'(lat), 64'd117);
    waitDrain();

    $display("[TB] backpressure job");
    stall_en = 1'b1;
    applyStimulus(8'h05, 16'h0000, 16'h0100, 18, 1'b0, 1'b0);
    waitDrain();
    stall_en = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] wrapped A, done on last allowed poll");
    for (int i = 0; i < NE; i++) exp_c[i] = 32'(((i + 8) % 16) + 1);
    done_on_read = PL;
    applyStimulus(8'h33, 16'hFFF8, 16'h0100, PL, 1'b0, 1'b0);
    waitDrain();

    $display("[TB] poll timeout");
    done_on_read = 0;
    applyStimulus(8'h44, 16'h0000, 16'h0100, PL, 1'b1, 1'b0);
    waitDrain();

    $display("[TB] back-to-back jobs");
    done_on_read = 18;
    for (int i = 0; i < NE; i++) exp_c[i] = 32'(i + 1);
    applyStimulus(8'h11, 16'h0000, 16'h0100, 18, 1'b0, 1'b0);
    for (int i = 0; i < NE; i++) exp_c[i] = 32'(2 * (16 - i));
    applyStimulus(8'h22, 16'h0040, 16'h0200, 18, 1'b0, 1'b1);
    waitDrain();

    $display("[TB] reset during LD_B");
    for (int i = 0; i < NE; i++) exp_c[i] = 32'(i + 1);
    applyStimulus(8'h55, 16'h0000, 16'h0100, 18, 1'b0, 1'b0);
    waited = 0;
    while (!(mmio_wr && mmio_addr[15:8] == 8'h02) && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (!(mmio_wr && mmio_addr[15:8] == 8'h02)) reportFail("ld_b_not_reached");
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetOutputs("midjob");
    mem_q.delete();
    mmio_q.delete();
    res_q.delete();
    done_q.delete();
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("post_reset");
    applyStimulus(8'h66, 16'h0000, 16'h0100, 18, 1'b0, 1'b0);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog in case a wait escapes its own bound.
  initial begin
    #400000;
    reportFail("global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
